// File: rtl/uart_word_bridge_if.sv
// rtl/uart_word_bridge_if.sv - handshake bundle between the word bridge, the UART pair and the PE
interface uart_word_bridge_if #(
  parameter int DATA_W = 32
);
  // Receiver -> bridge
  logic [7:0]        rx_data;
  logic              rx_new;
  // bridge -> PE (RX words)
  logic [DATA_W-1:0] in_word;
  logic              in_valid;
  logic              in_ready;
  // PE -> bridge (TX words)
  logic [DATA_W-1:0] out_word;
  logic              out_valid;
  logic              out_ready;
  // bridge <-> Sender
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;

  // Bridge side
  modport slave (
    input  rx_data, rx_new, in_ready, out_word, out_valid, tx_busy,
    output in_word, in_valid, out_ready, tx_data, tx_start
  );

  // Environment side (UART pair plus PE)
  modport master (
    output rx_data, rx_new, in_ready, out_word, out_valid, tx_busy,
    input  in_word, in_valid, out_ready, tx_data, tx_start
  );
endinterface

// File: rtl/uart_word_bridge.sv
// rtl/uart_word_bridge.sv - packs UART bytes into words for the PE and serialises PE words back out
module uart_word_bridge #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_word_bridge_if.slave      bus,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   overflow,
  output logic                   timeout_err,
  input  logic                   clear_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT != 0);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  // ---------------------------------------------------------------- RX assembly
  logic [BW-1:0]     byte_idx;
  logic [DATA_W-1:0] asm_word;
  logic [DATA_W-1:0] asm_next;
  logic [TW-1:0]     tmo_cnt;
  logic              push_req;
  logic              tmo_hit;

  // Merge the incoming byte into its little-endian slot of the partial word
  always_comb begin
    asm_next = asm_word;
    asm_next[8*byte_idx +: 8] = bus.rx_data;
  end

  assign push_req = bus.rx_new && (byte_idx == LAST_BYTE);
  // A byte arriving in the expiry cycle wins over the timeout
  assign tmo_hit  = TMO_EN && (byte_idx != '0) && (tmo_cnt == TMO_LIMIT) && !bus.rx_new;

  // Byte index, partial word and inter-byte timeout counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx <= '0;
      asm_word <= '0;
      tmo_cnt  <= '0;
    end else if (bus.rx_new) begin
      tmo_cnt <= '0;
      if (push_req) begin
        byte_idx <= '0;
        asm_word <= '0;
      end else begin
        byte_idx <= byte_idx + 1'b1;
        asm_word <= asm_next;
      end
    end else if (tmo_hit) begin
      byte_idx <= '0;
      asm_word <= '0;
      tmo_cnt  <= '0;
    end else if (TMO_EN && byte_idx != '0) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_next;
  logic [AW:0]       count;
  logic [AW:0]       count_after_pop;
  logic [AW:0]       count_next;
  logic              pop;
  logic              push_ok;
  logic              in_valid_q;
  logic [DATA_W-1:0] in_word_q;
  logic [DATA_W-1:0] head_next;

  // Pop is resolved first so a full FIFO can accept a word in the same cycle
  always_comb begin
    pop             = in_valid_q && bus.in_ready;
    count_after_pop = count - (AW + 1)'(pop);
    push_ok         = push_req && (count_after_pop != FULL_CNT);
    count_next      = count_after_pop + (AW + 1)'(push_ok);
    rd_next         = rd_ptr + AW'(pop);
    if (count_after_pop != '0) begin
      head_next = mem[rd_next];
    end else if (push_ok) begin
      head_next = asm_next;
    end else begin
      head_next = in_word_q;
    end
  end

  // Word storage; contents are only meaningful between rd_ptr and wr_ptr
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= asm_next;
    end
  end

  // Pointers, occupancy and the registered head word presented to the PE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_valid_q <= 1'b0;
      in_word_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr     <= rd_next;
      count      <= count_next;
      in_valid_q <= (count_next != '0);
      in_word_q  <= head_next;
    end
  end

  assign bus.in_word  = in_word_q;
  assign bus.in_valid = in_valid_q;
  assign fill_level   = count;

  // Sticky error flags; a new event outranks a clear in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
      if (tmo_hit) begin
        timeout_err <= 1'b1;
      end else if (clear_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- TX serialiser
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_GUARD,
    TX_WAIT
  } tx_state_t;

  tx_state_t         tx_state;
  logic [DATA_W-1:0] tx_word;
  logic [BW-1:0]     tx_cnt;
  logic              out_ready_q;
  logic              tx_start_q;
  logic [7:0]        tx_data_q;

  // Word-to-byte FSM; GUARD covers the cycle before the Sender raises isBusy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state    <= TX_IDLE;
      tx_word     <= '0;
      tx_cnt      <= '0;
      out_ready_q <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (out_ready_q && bus.out_valid) begin
            tx_word     <= bus.out_word;
            tx_cnt      <= '0;
            out_ready_q <= 1'b0;
            tx_state    <= TX_LOAD;
          end else begin
            out_ready_q <= 1'b1;
          end
        end
        TX_LOAD: begin
          if (!bus.tx_busy) begin
            tx_data_q  <= tx_word[8*tx_cnt +: 8];
            tx_start_q <= 1'b1;
            tx_state   <= TX_GUARD;
          end
        end
        TX_GUARD: begin
          tx_state <= TX_WAIT;
        end
        TX_WAIT: begin
          if (!bus.tx_busy) begin
            if (tx_cnt == LAST_BYTE) begin
              out_ready_q <= 1'b1;
              tx_state    <= TX_IDLE;
            end else begin
              tx_cnt   <= tx_cnt + 1'b1;
              tx_state <= TX_LOAD;
            end
          end
        end
        default: begin
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  assign bus.out_ready = out_ready_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;

endmodule
